instr_enc: RTL and testbench
============================

INSTR_ENC -- requirements
Module: instr_enc

Interface
REQ-001 Ports SHALL be: clk  input  1  single clock, all state updates on rising edge.
REQ-002 rstn  input  1  reset; asynchronous assertion, active-low.
REQ-003 in_valid  input  1  instruction request present.
REQ-004 in_ready  output  1  encoder can accept a request this cycle.
REQ-005 mnem  input  5  instruction index: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sltu, 6 addu, 7 subu, 8 sll, 9 nor, 10 srl, 11 sllv, 12 srlv, 13 addi, 14 ori, 15 lw, 16 sw, 17 beq, 18 lui, 19 slti, 20 bne, 21 andi, 22 j, 23 jal; 24-31 illegal.
REQ-006 rs, rt, rd, shamt  input  5 each  register and shift fields.
REQ-007 imm  input  16  I-type immediate; target  input  26  J-type target.
REQ-008 base_load  input  1  load base_addr into write pointer; base_addr  input  10  word address.
REQ-009 im_we  output  1  instruction-memory write strobe; im_ready  input  1  memory accepts the write.
REQ-010 im_addr  output  10  word address; im_wdata  output  32  encoded instruction.
REQ-011 err  output  1  one-cycle pulse on illegal mnem; wrap  output  1  sticky, pointer wrapped.
REQ-012 instr_cnt  output  11  number of words written since reset, saturating at 2047.

Function
REQ-013 States SHALL be IDLE and WR only.
REQ-014 in_ready SHALL be 1 in IDLE when base_load=0; 0 otherwise.
REQ-015 Accept = in_valid & in_ready; on legal accept, encoded word SHALL be registered into im_wdata and state SHALL go to WR at the next edge.
REQ-016 In WR, im_we SHALL be 1 and im_addr/im_wdata SHALL be held stable until im_we & im_ready.
REQ-017 On im_we & im_ready: pointer +1 (1023 -> 0 and wrap set), instr_cnt +1 (saturating), state -> IDLE; throughput one word per two cycles minimum.
REQ-018 Illegal accept (mnem 24-31): err=1 next cycle for one cycle, state stays IDLE, no write, pointer and instr_cnt unchanged.
REQ-019 base_load in IDLE SHALL set pointer to base_addr next edge and block accept that cycle; base_load in WR SHALL be ignored.
REQ-020 R-type (0-12): op=0, bits[25:21]=rs, [20:16]=rt, [15:11]=rd, [10:6]=shamt, [5:0]=funct; funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sltu 0x2B, addu 0x21, subu 0x23, sll 0x00, nor 0x27, srl 0x02, sllv 0x04, srlv 0x06.
REQ-021 sll/srl SHALL force rs field to 0; all other R-type SHALL force shamt field to 0.
REQ-022 I-type: [31:26]=op, [25:21]=rs, [20:16]=rt, [15:0]=imm; op addi 0x08, ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, lui 0x0F, slti 0x0A, bne 0x05, andi 0x0C; lui SHALL force rs to 0.
REQ-023 J-type: [31:26]=op (j 0x02, jal 0x03), [25:0]=target.
REQ-024 Unused inputs SHALL not affect im_wdata.

Reset
REQ-025 rstn=0 SHALL immediately force: state IDLE, im_we 0, im_addr 0, im_wdata 0, err 0, wrap 0, instr_cnt 0; in_ready 0 while rstn=0.
REQ-026 Reset asserted during WR SHALL abort the pending write with no memory side effect from this block; first accept allowed on the first edge after rstn release.

Verification
REQ-027 mnem=0 rs=1 rt=2 rd=3 shamt=9 -> next cycle im_we=1, im_addr=0, im_wdata=0x00221820.
REQ-028 base_load base_addr=5, then mnem=15 rs=29 rt=8 imm=4 -> im_addr=5, im_wdata=0x8FA80004; with im_ready=0 for 3 cycles, outputs held, single increment to 6 after acceptance.
REQ-029 mnem=8 rs=7 rt=3 rd=2 shamt=4 -> im_wdata=0x00031100; mnem=22 target=0x10 -> im_wdata=0x08000010.
REQ-030 mnem=25 -> err pulse one cycle, im_we stays 0, im_addr and instr_cnt unchanged.
REQ-031 base_addr=1023, two legal writes -> addresses 1023 then 0, wrap=1 and stays 1, instr_cnt=2.
REQ-032 rstn pulled low mid-WR with im_ready=0 -> im_we drops to 0 asynchronously, all outputs at reset values.

Source files
------------

// File: rtl/instr_enc_if.sv
// Request and instruction-memory write signals for the instruction encoder.
// slave is the encoder's view; master is the requester/memory side.
interface instr_enc_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic        base_load;
    logic [9:0]  base_addr;
    logic        im_we;
    logic        im_ready;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic        err;
    logic        wrap;
    logic [10:0] instr_cnt;

    modport slave (
        input  in_valid, mnem, rs, rt, rd, shamt, imm, target, base_load, base_addr, im_ready,
        output in_ready, im_we, im_addr, im_wdata, err, wrap, instr_cnt
    );

    modport master (
        output in_valid, mnem, rs, rt, rd, shamt, imm, target, base_load, base_addr, im_ready,
        input  in_ready, im_we, im_addr, im_wdata, err, wrap, instr_cnt
    );
endinterface

// File: rtl/instr_enc.sv
// MIPS-style instruction encoder: takes a mnemonic index plus fields, builds the 32-bit word
// and writes it to instruction memory at an auto-incrementing word pointer.
module instr_enc (
    input logic      clk,
    input logic      rstn,
    instr_enc_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StWr} state_e;
    typedef enum logic [1:0] {KindR, KindI, KindJ, KindBad} kind_e;

    state_e      state_q, state_d;
    logic [9:0]  ptr_q, ptr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        wrap_q, wrap_d;
    logic [10:0] cnt_q, cnt_d;

    kind_e       kind;
    logic [5:0]  code;
    logic [31:0] enc;
    logic        in_ready;
    logic        accept;
    logic        is_shift_imm;
    logic        is_lui;

    always_comb begin
        kind = KindBad;
        code = 6'h00;
        case (bus.mnem)
            5'd0:  begin kind = KindR; code = 6'h20; end
            5'd1:  begin kind = KindR; code = 6'h22; end
            5'd2:  begin kind = KindR; code = 6'h24; end
            5'd3:  begin kind = KindR; code = 6'h25; end
            5'd4:  begin kind = KindR; code = 6'h2A; end
            5'd5:  begin kind = KindR; code = 6'h2B; end
            5'd6:  begin kind = KindR; code = 6'h21; end
            5'd7:  begin kind = KindR; code = 6'h23; end
            5'd8:  begin kind = KindR; code = 6'h00; end
            5'd9:  begin kind = KindR; code = 6'h27; end
            5'd10: begin kind = KindR; code = 6'h02; end
            5'd11: begin kind = KindR; code = 6'h04; end
            5'd12: begin kind = KindR; code = 6'h06; end
            5'd13: begin kind = KindI; code = 6'h08; end
            5'd14: begin kind = KindI; code = 6'h0D; end
            5'd15: begin kind = KindI; code = 6'h23; end
            5'd16: begin kind = KindI; code = 6'h2B; end
            5'd17: begin kind = KindI; code = 6'h04; end
            5'd18: begin kind = KindI; code = 6'h0F; end
            5'd19: begin kind = KindI; code = 6'h0A; end
            5'd20: begin kind = KindI; code = 6'h05; end
            5'd21: begin kind = KindI; code = 6'h0C; end
            5'd22: begin kind = KindJ; code = 6'h02; end
            5'd23: begin kind = KindJ; code = 6'h03; end
            default: begin kind = KindBad; code = 6'h00; end
        endcase
    end

    // Only the shift-by-immediate ops carry shamt; they and lui have no rs operand.
    assign is_shift_imm = (bus.mnem == 5'd8) || (bus.mnem == 5'd10);
    assign is_lui       = (bus.mnem == 5'd18);

    always_comb begin
        enc = 32'h0;
        case (kind)
            KindR: enc = {6'h00, is_shift_imm ? 5'd0 : bus.rs, bus.rt, bus.rd,
                          is_shift_imm ? bus.shamt : 5'd0, code};
            KindI: enc = {code, is_lui ? 5'd0 : bus.rs, bus.rt, bus.imm};
            KindJ: enc = {code, bus.target};
            default: enc = 32'h0;
        endcase
    end

    // Gated by rstn so the requester sees not-ready for the whole reset interval.
    assign in_ready = rstn && (state_q == StIdle) && !bus.base_load;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        wrap_d  = wrap_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.base_load) begin
                    ptr_d = bus.base_addr;
                end else if (accept) begin
                    if (kind != KindBad) begin
                        wdata_d = enc;
                        state_d = StWr;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StWr: begin
                if (bus.im_ready) begin
                    ptr_d   = ptr_q + 10'd1;
                    state_d = StIdle;
                    if (ptr_q == 10'h3FF) wrap_d = 1'b1;
                    if (cnt_q != 11'h7FF) cnt_d = cnt_q + 11'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            ptr_q   <= 10'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= 11'h0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.im_we     = (state_q == StWr);
    assign bus.im_addr   = ptr_q;
    assign bus.im_wdata  = wdata_q;
    assign bus.err       = err_q;
    assign bus.wrap      = wrap_q;
    assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_instr_enc.sv
// Scoreboard bench for instr_enc: expected writes are queued on request and compared
// when the encoder completes the memory handshake.
module tb_instr_enc;

    logic clk;
    logic rstn;
    instr_enc_if ifc ();

    instr_enc dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [41:0] exp_q[$];
    logic [9:0]  m_ptr;
    logic [10:0] m_cnt;
    logic        m_wrap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Independent reference encoder: returns {legal, word}.
    function automatic logic [32:0] ref_enc(input logic [4:0] m, input logic [4:0] rs_v,
                                            input logic [4:0] rt_v, input logic [4:0] rd_v,
                                            input logic [4:0] sh_v, input logic [15:0] im_v,
                                            input logic [25:0] tg_v);
        logic [31:0] w;
        int f;
        int op;
        w = 32'h0;
        case (m)
            0: f = 32'h20;  1: f = 32'h22;  2: f = 32'h24;  3: f = 32'h25;
            4: f = 32'h2A;  5: f = 32'h2B;  6: f = 32'h21;  7: f = 32'h23;
            8: f = 32'h00;  9: f = 32'h27;  10: f = 32'h02; 11: f = 32'h04;
            12: f = 32'h06;
            default: f = -1;
        endcase
        if (f >= 0) begin
            w = (32'(rt_v) << 16) | (32'(rd_v) << 11) | 32'(f);
            if (m == 5'd8 || m == 5'd10) w = w | (32'(sh_v) << 6);
            else                         w = w | (32'(rs_v) << 21);
            return {1'b1, w};
        end
        case (m)
            13: op = 8;  14: op = 13; 15: op = 35; 16: op = 43; 17: op = 4;
            18: op = 15; 19: op = 10; 20: op = 5;  21: op = 12; 22: op = 2;
            23: op = 3;
            default: op = -1;
        endcase
        if (op < 0) return 33'h0;
        if (m >= 5'd22) begin
            w = (32'(op) << 26) | 32'(tg_v);
        end else begin
            w = (32'(op) << 26) | (32'(rt_v) << 16) | 32'(im_v);
            if (m != 5'd18) w = w | (32'(rs_v) << 21);
        end
        return {1'b1, w};
    endfunction

    task automatic scramble();
        ifc.mnem   = 5'($urandom);
        ifc.rs     = 5'($urandom);
        ifc.rt     = 5'($urandom);
        ifc.rd     = 5'($urandom);
        ifc.shamt  = 5'($urandom);
        ifc.imm    = 16'($urandom);
        ifc.target = 26'($urandom);
    endtask

    task automatic do_base(input logic [9:0] a);
        @(negedge clk);
        ifc.base_load = 1'b1;
        ifc.base_addr = a;
        ifc.in_valid  = 1'b1;
        ifc.mnem      = 5'd0;
        #1 chk("bl_ready", 32'(ifc.in_ready), 32'd0);
        @(negedge clk);
        ifc.base_load = 1'b0;
        ifc.in_valid  = 1'b0;
        m_ptr = a;
        #1;
        chk("bl_addr", 32'(ifc.im_addr), 32'(a));
        chk("bl_no_we", 32'(ifc.im_we), 32'd0);
    endtask

    task automatic do_req(input logic [4:0] m, input logic [4:0] a_rs, input logic [4:0] a_rt,
                          input logic [4:0] a_rd, input logic [4:0] a_sh,
                          input logic [15:0] a_imm, input logic [25:0] a_tg,
                          input int stall, input bit bl_in_wr);
        logic [32:0] r;
        logic [41:0] e;
        logic [9:0]  a0;
        logic [10:0] c0;
        r  = ref_enc(m, a_rs, a_rt, a_rd, a_sh, a_imm, a_tg);
        a0 = m_ptr;
        c0 = m_cnt;
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.mnem = m; ifc.rs = a_rs; ifc.rt = a_rt; ifc.rd = a_rd; ifc.shamt = a_sh;
        ifc.imm = a_imm; ifc.target = a_tg; ifc.im_ready = 1'b0;
        #1 chk("in_ready", 32'(ifc.in_ready), 32'd1);
        if (r[32]) exp_q.push_back({m_ptr, r[31:0]});
        @(negedge clk);
        ifc.in_valid = 1'b0;
        scramble();
        #1;
        if (r[32]) begin
            chk("wr_we", 32'(ifc.im_we), 32'd1);
            chk("wr_ready_low", 32'(ifc.in_ready), 32'd0);
            for (int i = 0; i < stall; i++) begin
                chk("hold_addr", 32'(ifc.im_addr), 32'(exp_q[0][41:32]));
                chk("hold_data", ifc.im_wdata, exp_q[0][31:0]);
                chk("hold_we", 32'(ifc.im_we), 32'd1);
                if (bl_in_wr && i == 0) begin
                    ifc.base_load = 1'b1;
                    ifc.base_addr = ~a0;
                end
                @(negedge clk);
                ifc.base_load = 1'b0;
                scramble();
                #1;
            end
            ifc.im_ready = 1'b1;
            #1;
            if (ifc.im_we && ifc.im_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(ifc.im_addr), 32'(e[41:32]));
                chk("wr_data", ifc.im_wdata, e[31:0]);
            end else begin
                chk("wr_handshake", 32'(ifc.im_we), 32'd1);
            end
            @(negedge clk);
            ifc.im_ready = 1'b0;
            if (m_ptr == 10'h3FF) m_wrap = 1'b1;
            m_ptr = m_ptr + 10'd1;
            if (m_cnt != 11'h7FF) m_cnt = m_cnt + 11'd1;
            #1;
            chk("post_we", 32'(ifc.im_we), 32'd0);
            chk("post_ptr", 32'(ifc.im_addr), 32'(m_ptr));
            chk("post_cnt", 32'(ifc.instr_cnt), 32'(m_cnt));
            chk("post_wrap", 32'(ifc.wrap), 32'(m_wrap));
        end else begin
            chk("ill_err", 32'(ifc.err), 32'd1);
            chk("ill_we", 32'(ifc.im_we), 32'd0);
            chk("ill_addr", 32'(ifc.im_addr), 32'(a0));
            chk("ill_cnt", 32'(ifc.instr_cnt), 32'(c0));
            @(negedge clk);
            #1;
            chk("ill_err_pulse", 32'(ifc.err), 32'd0);
            chk("ill_we2", 32'(ifc.im_we), 32'd0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"},    32'(ifc.im_we), 32'd0);
        chk({tag, "_addr"},  32'(ifc.im_addr), 32'd0);
        chk({tag, "_wdata"}, ifc.im_wdata, 32'd0);
        chk({tag, "_err"},   32'(ifc.err), 32'd0);
        chk({tag, "_wrap"},  32'(ifc.wrap), 32'd0);
        chk({tag, "_cnt"},   32'(ifc.instr_cnt), 32'd0);
        chk({tag, "_rdy"},   32'(ifc.in_ready), 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        ifc.in_valid = 1'b0; ifc.base_load = 1'b0; ifc.base_addr = 10'h0;
        ifc.im_ready = 1'b0;
        ifc.mnem = 5'd0; ifc.rs = 5'd0; ifc.rt = 5'd0; ifc.rd = 5'd0; ifc.shamt = 5'd0;
        ifc.imm = 16'h0; ifc.target = 26'h0;
        m_ptr = 10'h0; m_cnt = 11'h0; m_wrap = 1'b0;
        #1;
        ifc.in_valid = 1'b1;
        #1 chk_reset_vals("rst");
        ifc.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Directed vectors
        do_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd9, 16'h0, 26'h0, 0, 1'b0);
        chk("vec_add_const", 32'(ref_enc(5'd0, 5'd1, 5'd2, 5'd3, 5'd9, 16'h0, 26'h0)),
            32'h00221820);
        do_base(10'd5);
        do_req(5'd15, 5'd29, 5'd8, 5'd0, 5'd0, 16'd4, 26'h0, 3, 1'b0);
        chk("lw_ptr6", 32'(ifc.im_addr), 32'd6);
        do_req(5'd8, 5'd7, 5'd3, 5'd2, 5'd4, 16'hFFFF, 26'h3FFFFFF, 1, 1'b0);
        do_req(5'd22, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h10, 0, 1'b0);
        do_req(5'd25, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0, 0, 1'b0);
        do_req(5'd18, 5'd9, 5'd4, 5'd0, 5'd0, 16'hABCD, 26'h0, 2, 1'b1);

        // Random mix including illegal indices
        for (int n = 0; n < 40; n++) begin
            do_req(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   16'($urandom), 26'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        // Reset asserted during a stalled write
        @(negedge clk);
        ifc.in_valid = 1'b1; ifc.mnem = 5'd1; ifc.im_ready = 1'b0;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        #1 chk("rstwr_we", 32'(ifc.im_we), 32'd1);
        #2 rstn = 1'b0;
        #1 chk_reset_vals("rstwr");
        @(negedge clk);
        rstn = 1'b1;
        m_ptr = 10'h0; m_cnt = 11'h0; m_wrap = 1'b0;

        // Pointer wrap
        do_base(10'd1023);
        do_req(5'd13, 5'd1, 5'd2, 5'd0, 5'd0, 16'h7, 26'h0, 0, 1'b0);
        do_req(5'd14, 5'd3, 5'd4, 5'd0, 5'd0, 16'h8, 26'h0, 1, 1'b0);
        chk("wrap_cnt2", 32'(ifc.instr_cnt), 32'd2);
        chk("wrap_set", 32'(ifc.wrap), 32'd1);
        do_req(5'd23, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h155, 0, 1'b0);
        chk("wrap_sticky", 32'(ifc.wrap), 32'd1);

        // Counter saturation
        for (int n = 0; n < 2050; n++) begin
            do_req(5'(n % 24), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   16'($urandom), 26'($urandom), 0, 1'b0);
        end
        chk("cnt_sat", 32'(ifc.instr_cnt), 32'd2047);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
